// File: rtl/seq_mult_param.sv
// Iterative sign-magnitude multiplier: STEP multiplier bits per cycle, early exit
// once the remaining multiplier bits are all zero, with a cancellable run phase.
module seq_mult_param #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic                 cancel,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    ONE_P = {{(PW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A most-negative operand wraps back onto itself, which is exactly its unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return (~v) + ONE_W;
    end else begin
      return v;
    end
  endfunction

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic neg);
    if (neg) begin
      return (~v) + ONE_P;
    end else begin
      return v;
    end
  endfunction

  state_t            state_r;
  state_t            state_next_s;
  logic [PW-1:0]     mcand_r;
  logic [WIDTH-1:0]  mplier_r;
  logic [PW-1:0]     acc_r;
  logic              sign_r;
  logic [PW-1:0]     product_r;

  logic [PW-1:0]     partial_s;
  logic [PW-1:0]     acc_next_s;
  logic [PW-1:0]     mcand_next_s;
  logic [WIDTH-1:0]  mplier_next_s;
  logic              last_s;
  logic [WIDTH-1:0]  mag_a_s;
  logic [WIDTH-1:0]  mag_b_s;
  logic              sign_s;

  // Operand conditioning for a newly accepted operation
  always_comb begin
    mag_a_s = magnitude(op_a, signed_mode);
    mag_b_s = magnitude(op_b, signed_mode);
    sign_s  = signed_mode & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
  end

  // Shift-and-add of the low STEP multiplier bits for this iteration
  always_comb begin
    partial_s = '0;
    for (int i = 0; i < STEP; i++) begin
      if (mplier_r[i]) begin
        partial_s = partial_s + (mcand_r << i);
      end else begin
        partial_s = partial_s;
      end
    end
    acc_next_s    = acc_r + partial_s;
    mcand_next_s  = mcand_r << STEP;
    mplier_next_s = mplier_r >> STEP;
    last_s        = (mplier_next_s == '0);
  end

  // Next-state logic; cancel outranks completion
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (cancel) begin
          state_next_s = IDLE;
        end else if (last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath registers; product only changes on the completing edge
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mcand_r   <= '0;
      mplier_r  <= '0;
      acc_r     <= '0;
      sign_r    <= 1'b0;
      product_r <= '0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            mcand_r  <= {{WIDTH{1'b0}}, mag_a_s};
            mplier_r <= mag_b_s;
            sign_r   <= sign_s;
            acc_r    <= '0;
          end
        end
        RUN: begin
          if (!cancel) begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_next_s;
            mplier_r <= mplier_next_s;
            if (last_s) begin
              product_r <= apply_sign(acc_next_s, sign_r);
            end
          end
        end
        default: begin
          mcand_r <= mcand_r;
        end
      endcase
    end
  end

  assign ready   = (state_r != RUN);
  assign busy    = (state_r == RUN);
  assign done    = (state_r == DONE);
  assign product = product_r;

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param: one WIDTH=32/STEP=1 instance and one
// WIDTH=32/STEP=4 instance, hand-computed products and latencies.
module tb_seq_mult_param;

  logic        clk = 1'b0;
  logic        resetn;
  always #5 clk = ~clk;

  logic        start1, sm1, cancel1;
  logic [31:0] a1, b1;
  logic        ready1, busy1, done1;
  logic [63:0] prod1;

  logic        start4, sm4, cancel4;
  logic [31:0] a4, b4;
  logic        ready4, busy4, done4;
  logic [63:0] prod4;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mult_param #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .resetn(resetn), .start(start1), .signed_mode(sm1),
    .op_a(a1), .op_b(b1), .cancel(cancel1),
    .ready(ready1), .busy(busy1), .done(done1), .product(prod1)
  );

  seq_mult_param #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .resetn(resetn), .start(start4), .signed_mode(sm4),
    .op_a(a4), .op_b(b4), .cancel(cancel4),
    .ready(ready4), .busy(busy4), .done(done4), .product(prod4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; drives start for one cycle and returns just after the accepting edge.
  task automatic start_op(input bit d4, input bit sm, input logic [31:0] a, input logic [31:0] b,
                          input bit with_cancel);
    check("ready_before_start", d4 ? ready4 : ready1, 64'd1);
    if (d4) begin
      start4 = 1'b1; sm4 = sm; a4 = a; b4 = b; cancel4 = with_cancel;
    end else begin
      start1 = 1'b1; sm1 = sm; a1 = a; b1 = b; cancel1 = with_cancel;
    end
    @(negedge clk);
    start1 = 1'b0; cancel1 = 1'b0;
    start4 = 1'b0; cancel4 = 1'b0;
  endtask

  // Counts edges after acceptance until done; optionally injects a stray start while running.
  task automatic wait_done(input bit d4, input string tag, input int exp_n,
                           input logic [63:0] exp_p, input int stray_k);
    int k = 0;
    int bcnt = 0;
    while (!(d4 ? done4 : done1) && k < 200) begin
      bcnt += int'(d4 ? busy4 : busy1);
      if (!d4 && k == stray_k) begin
        start1 = 1'b1; sm1 = 1'b1; a1 = 32'd1; b1 = 32'd1;
      end else begin
        start1 = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start1 = 1'b0;
    check({tag, "_latency"}, 64'(k), 64'(exp_n));
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_n));
    check({tag, "_product"}, d4 ? prod4 : prod1, exp_p);
    check({tag, "_ready_in_done"}, d4 ? ready4 : ready1, 64'd1);
  endtask

  task automatic done_low(input bit d4, input string tag);
    @(negedge clk);
    check({tag, "_done_pulse_end"}, d4 ? done4 : done1, 64'd0);
    check({tag, "_idle_busy"}, d4 ? busy4 : busy1, 64'd0);
  endtask

  initial begin
    resetn = 1'b0;
    start1 = 1'b0; sm1 = 1'b0; cancel1 = 1'b0; a1 = 32'd0; b1 = 32'd0;
    start4 = 1'b0; sm4 = 1'b0; cancel4 = 1'b0; a4 = 32'd0; b4 = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready1, 64'd1);
    check("rst_busy", busy1, 64'd0);
    check("rst_done", done1, 64'd0);
    check("rst_product", prod1, 64'd0);
    check("rst4_product", prod4, 64'd0);
    resetn = 1'b1;

    // Unsigned all-ones squared: full 32 iterations
    start_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(1'b0, "u_max", 32, 64'hFFFF_FFFE_0000_0001, -1);
    done_low(1'b0, "u_max");

    // Signed -2 * 3, then -2 * 0
    start_op(1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_done(1'b0, "s_m2x3", 2, 64'hFFFF_FFFF_FFFF_FFFA, -1);
    done_low(1'b0, "s_m2x3");
    start_op(1'b0, 1'b1, 32'hFFFF_FFFE, 32'd0, 1'b0);
    wait_done(1'b0, "s_m2x0", 1, 64'd0, -1);
    done_low(1'b0, "s_m2x0");

    // Most-negative operands, signed then unsigned (cancel while idle must be ignored)
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_done(1'b0, "s_minneg", 32, 64'h4000_0000_0000_0000, -1);
    done_low(1'b0, "s_minneg");
    start_op(1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done(1'b0, "u_msb", 32, 64'h4000_0000_0000_0000, -1);
    done_low(1'b0, "u_msb");

    // Cancel on the 5th RUN cycle; product must keep the prior result
    start_op(1'b0, 1'b0, 32'h1234_5678, 32'hFFFF_0000, 1'b0);
    repeat (4) @(negedge clk);
    check("cancel_busy_before", busy1, 64'd1);
    cancel1 = 1'b1;
    @(negedge clk);
    cancel1 = 1'b0;
    check("cancel_ready", ready1, 64'd1);
    check("cancel_busy", busy1, 64'd0);
    check("cancel_done", done1, 64'd0);
    check("cancel_product_held", prod1, 64'h4000_0000_0000_0000);
    @(negedge clk);
    check("cancel_no_late_done", done1, 64'd0);
    // Restart, with a stray start mid-run that must be ignored
    start_op(1'b0, 1'b0, 32'h1234_5678, 32'hFFFF_0000, 1'b0);
    wait_done(1'b0, "restart", 32, 64'h1234_4443_A988_0000, 3);
    done_low(1'b0, "restart");

    // Back-to-back: second start held in the DONE cycle
    start_op(1'b0, 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_done(1'b0, "b2b_1", 2, 64'hFFFF_FFFF_FFFF_FFFA, -1);
    start_op(1'b0, 1'b0, 32'd7, 32'd5, 1'b0);
    wait_done(1'b0, "b2b_2", 3, 64'd35, -1);
    done_low(1'b0, "b2b_2");

    // Asynchronous reset in the middle of a run
    start_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (3) @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    check("midrst_ready", ready1, 64'd1);
    check("midrst_busy", busy1, 64'd0);
    check("midrst_done", done1, 64'd0);
    check("midrst_product", prod1, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    check("postrst_done", done1, 64'd0);
    start_op(1'b0, 1'b0, 32'd3, 32'd3, 1'b0);
    wait_done(1'b0, "postrst", 2, 64'd9, -1);
    done_low(1'b0, "postrst");

    // STEP=4 instance
    start_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(1'b1, "s4_max", 8, 64'hFFFF_FFFE_0000_0001, -1);
    done_low(1'b1, "s4_max");
    start_op(1'b1, 1'b1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    wait_done(1'b1, "s4_m2x3", 1, 64'hFFFF_FFFF_FFFF_FFFA, -1);
    done_low(1'b1, "s4_m2x3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mult_param.md
SEQ_MULT_PARAM -- requirements
Module: seq_mult_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand width in bits, legal values 8 to 64.
REQ-002 The block SHALL have parameter STEP, default 1: multiplier bits consumed per cycle, one of 1, 2 or 4, and it SHALL divide WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 The block SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to accept a new operation.
REQ-006 The block SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 The block SHALL have ports op_a and op_b, input, WIDTH bits each: multiplicand and multiplier; sampled with start.
REQ-008 The block SHALL have port cancel, input, 1 bit: aborts an operation in progress.
REQ-009 The block SHALL have port ready, output, 1 bit: high when start will be accepted.
REQ-010 The block SHALL have port busy, output, 1 bit: high while iterating.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse marking a valid new product.
REQ-012 The block SHALL have port product, output, 2*WIDTH bits: registered result.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE; ready = (state != RUN); busy = (state == RUN); done = (state == DONE).
REQ-014 In IDLE or DONE with start=1, the next edge SHALL latch the following values and enter RUN:
- |op_a| zero-extended to 2*WIDTH as the multiplicand;
- |op_b| as the multiplier;
- result sign = signed_mode & (op_a[msb] ^ op_b[msb]);
- accumulator cleared.
REQ-015 Absolute values SHALL be taken only when signed_mode=1 and the operand msb=1; a most-negative operand SHALL yield 2^(WIDTH-1) as an unsigned magnitude with no overflow.
REQ-016 Each RUN edge SHALL perform:
- accumulator += multiplicand * multiplier[STEP-1:0];
- multiplicand shifted left by STEP;
- multiplier shifted right logically by STEP.
REQ-017 Early termination: RUN SHALL go to DONE on the edge where the shifted multiplier becomes zero; RUN SHALL otherwise stay in RUN, so N = max(1, ceil(bitlen(|op_b|)/STEP)) RUN cycles, where N <= WIDTH/STEP.
REQ-018 On the RUN->DONE edge, product SHALL be loaded with the accumulator (final term included), two's-complement negated when result sign=1.
REQ-019 done SHALL be high exactly in the cycle beginning N edges after the accepting edge, for exactly one cycle.
REQ-020 Product hold:
- product SHALL hold its value until the next RUN->DONE edge;
- start acceptance, cancel and illegal start SHALL NOT alter product.
REQ-021 DONE without start SHALL return to IDLE; DONE with start SHALL enter RUN (back-to-back, zero idle cycles).
REQ-022 start while in RUN SHALL be ignored with no side effects.
REQ-023 cancel while in RUN SHALL force IDLE on the next edge with no done pulse; cancel has priority over completion in the same cycle.
REQ-024 cancel in IDLE or DONE SHALL be ignored; start is still honoured.
REQ-025 All arithmetic SHALL be exact modulo 2^(2*WIDTH) and SHALL never overflow for any legal operand pair.

Reset
REQ-026 resetn=0 SHALL, asynchronously and regardless of state (including mid-RUN), force the following; no done pulse SHALL follow reset release:
- state IDLE;
- ready=1, busy=0, done=0;
- product=0;
- internal operand, accumulator and sign registers = 0.
REQ-027 The first edge after resetn rises SHALL be able to accept start.

Verification (WIDTH=32, STEP=1 unless stated)
REQ-028 The bench SHALL cover unsigned 0xFFFFFFFF * 0xFFFFFFFF -> product 0xFFFFFFFE00000001, done 32 edges after acceptance, busy high for 32 cycles.
REQ-029 The bench SHALL cover signed -2 (0xFFFFFFFE) * 3 -> product 0xFFFFFFFFFFFFFFFA, done 2 edges after acceptance; then op_b=0 -> product 0, done after 1 edge.
REQ-030 The bench SHALL cover signed 0x80000000 * 0x80000000 -> 0x4000000000000000, and unsigned on the same operands -> 0x4000000000000000, done after 32 edges.
REQ-031 The bench SHALL cover cancel asserted on the 5th RUN cycle of 0x12345678 * 0xFFFF0000 -> IDLE next edge, no done, product still the prior result. An immediate restart SHALL then complete correctly.
REQ-032 The bench SHALL cover back-to-back starts held in the DONE cycle -> second done exactly N2 edges after the first done; each product SHALL be correct.
REQ-033 The bench SHALL cover resetn pulsed low mid-RUN -> immediate ready=1, busy=0, done=0, product=0. With STEP=4, 0xFFFFFFFF * 0xFFFFFFFF SHALL give done after 8 edges with the same product.
